// File: rtl/back_icon_dispatch_scheduler_pkg.sv
// Shared types for the interconnect dispatch scheduler: instruction format, counter width and
// scheduler FSM states.
package back_icon_dispatch_scheduler_pkg;

  localparam int unsigned ICON_DISPATCH_CNT_W = 16;
  localparam int unsigned ICON_EUIDX_W        = 4;

  typedef struct packed {
    logic [ICON_EUIDX_W-1:0] euidx;
    logic [3:0]              port;
  } type_icon_addr;

  typedef struct packed {
    logic [3:0]    opcode;
    type_icon_addr src_addr;
    type_icon_addr dst_addr;
    logic [15:0]   payload;
  } type_icon_instr;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } type_icon_sched_state;

endpackage

// File: rtl/back_icon_dispatch_scheduler_if.sv
// Front-end handshake and per-channel dispatch bus of the dispatch scheduler.
// Signal directions are named from the scheduler's point of view (slave modport).
interface back_icon_dispatch_scheduler_if #(
  parameter int unsigned N = 4
);
  import back_icon_dispatch_scheduler_pkg::*;

  type_icon_instr         instr_i;
  logic                   instr_valid_i;
  logic                   instr_ready_o;
  logic                   flush_i;
  type_icon_instr [N-1:0] dispatch_o;
  logic [N-1:0]           dispatch_valid_o;
  logic [N-1:0]           dispatch_ready_i;

  modport master (
    output instr_i, instr_valid_i, flush_i, dispatch_ready_i,
    input  instr_ready_o, dispatch_o, dispatch_valid_o
  );

  modport slave (
    input  instr_i, instr_valid_i, flush_i, dispatch_ready_i,
    output instr_ready_o, dispatch_o, dispatch_valid_o
  );

endinterface

// File: rtl/back_icon_rr_picker.sv
// Combinational round-robin picker: first set request scanning from i_ptr upward, modulo N.
module back_icon_rr_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);

  always_comb begin
    int unsigned j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(i_ptr) + k) % N;
      if (!o_valid && i_req[j[IdxW-1:0]]) begin
        o_valid                 = 1'b1;
        o_idx                   = j[IdxW-1:0];
        o_grant[j[IdxW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/back_icon_dispatch_scheduler.sv
// Buffers front-end instructions and steers each to one ready interconnect channel, round-robin.
// Optional ICON_SRC_AFFINITY_EN pins each source euidx to the channel it first went to.
module back_icon_dispatch_scheduler
  import back_icon_dispatch_scheduler_pkg::*;
#(
  parameter int unsigned NUM_ICON_CHANNELS = 4,
  parameter int unsigned LOG2_BUF_DEPTH    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  back_icon_dispatch_scheduler_if.slave  icon_if,
  output logic [ICON_DISPATCH_CNT_W-1:0] dispatched_count_o,
  output logic                           busy_o
);

  localparam int unsigned N     = NUM_ICON_CHANNELS;
  localparam int unsigned L     = LOG2_BUF_DEPTH;
  localparam int unsigned Depth = 2 ** L;
  localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;

  type_icon_instr                 r_buf [Depth];
  logic [L:0]                     r_wr_ptr, r_rd_ptr;
  logic [L:0]                     w_wr_ptr_next, w_rd_ptr_next;
  logic [IdxW-1:0]                r_rr_ptr;
  logic [ICON_DISPATCH_CNT_W-1:0] r_count;
  type_icon_sched_state           r_state, w_state_next;

  logic           w_empty, w_full, w_push, w_pop, w_can_disp;
  type_icon_instr w_head;
  logic [N-1:0]   w_req_raw, w_req, w_grant;
  logic [IdxW-1:0] w_grant_idx;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[L] != r_rd_ptr[L]) && (r_wr_ptr[L-1:0] == r_rd_ptr[L-1:0]);
  assign w_head  = r_buf[r_rd_ptr[L-1:0]];

  // Registered-only ready: no path from the channel side back to the front end.
  assign icon_if.instr_ready_o = ~w_full & (r_state != FLUSH);
  assign w_push = icon_if.instr_valid_i & icon_if.instr_ready_o & ~icon_if.flush_i;

  assign w_can_disp = ~w_empty & ~icon_if.flush_i & (r_state != FLUSH);

`ifdef ICON_SRC_AFFINITY_EN
  localparam int unsigned AffEntries = 2 ** ICON_EUIDX_W;

  logic [AffEntries-1:0]   r_aff_valid;
  logic [IdxW-1:0]         r_aff_chan [AffEntries];
  logic [ICON_EUIDX_W-1:0] w_head_eu;

  assign w_head_eu = w_head.src_addr.euidx;

  // A pinned source may only use its own channel; if that one is busy the head stalls.
  always_comb begin
    w_req_raw = icon_if.dispatch_ready_i;
    if (r_aff_valid[w_head_eu]) begin
      w_req_raw                         = '0;
      w_req_raw[r_aff_chan[w_head_eu]]  = icon_if.dispatch_ready_i[r_aff_chan[w_head_eu]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || icon_if.flush_i) begin
      r_aff_valid <= '0;
    end else if (w_pop && !r_aff_valid[w_head_eu]) begin
      r_aff_valid[w_head_eu] <= 1'b1;
      r_aff_chan[w_head_eu]  <= w_grant_idx;
    end
  end
`else
  assign w_req_raw = icon_if.dispatch_ready_i;
`endif

  assign w_req = w_req_raw & {N{w_can_disp}};

  back_icon_rr_picker #(
    .N (N)
  ) u_rr_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_valid (w_pop)
  );

  assign icon_if.dispatch_valid_o = w_grant;

  always_comb begin
    icon_if.dispatch_o = '0;
    for (int unsigned c = 0; c < N; c++) begin
      if (w_grant[c]) icon_if.dispatch_o[c] = w_head;
    end
  end

  assign w_wr_ptr_next = r_wr_ptr + {{L{1'b0}}, w_push};
  assign w_rd_ptr_next = r_rd_ptr + {{L{1'b0}}, w_pop};

  always_comb begin
    w_state_next = r_state;
    if (icon_if.flush_i) begin
      w_state_next = FLUSH;
    end else if (r_state == FLUSH) begin
      w_state_next = IDLE;
    end else begin
      w_state_next = (w_wr_ptr_next != w_rd_ptr_next) ? ACTIVE : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rr_ptr <= '0;
      r_count  <= '0;
      r_state  <= IDLE;
    end else if (icon_if.flush_i) begin
      // rr_ptr and the dispatch count survive a flush.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= FLUSH;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_state  <= w_state_next;
      if (w_pop) begin
        r_rr_ptr <= (w_grant_idx == IdxW'(N - 1)) ? '0 : w_grant_idx + 1'b1;
        if (r_count != '1) r_count <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr[L-1:0]] <= icon_if.instr_i;
  end

  assign dispatched_count_o = r_count;
  assign busy_o             = ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_back_icon_dispatch_scheduler.sv
// Scoreboard bench for back_icon_dispatch_scheduler: directed stimulus queues expected
// {channel, instr} pairs, a negedge monitor checks every dispatch against them.
module tb_back_icon_dispatch_scheduler;
  import back_icon_dispatch_scheduler_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] dispatched_count;
  logic        busy;

  back_icon_dispatch_scheduler_if #(.N(4)) u_if ();

  back_icon_dispatch_scheduler #(
    .NUM_ICON_CHANNELS (4),
    .LOG2_BUF_DEPTH    (1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .icon_if            (u_if),
    .dispatched_count_o (dispatched_count),
    .busy_o             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             chan;
    type_icon_instr ins;
  } exp_t;

  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = '0;
  int          m_rr     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic type_icon_instr mk(input logic [3:0] eu, input logic [15:0] pay);
    type_icon_instr t;
    t                = '0;
    t.opcode         = pay[3:0];
    t.src_addr.euidx = eu;
    t.dst_addr.port  = pay[7:4];
    t.payload        = pay;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // ch < 0: instruction is not expected to be dispatched (dropped or stalled).
  task automatic push_instr(input type_icon_instr ins, input int ch);
    exp_t e;
    u_if.instr_i       = ins;
    u_if.instr_valid_i = 1'b1;
    if (ch >= 0) begin
      e.chan = ch;
      e.ins  = ins;
      exp_q.push_back(e);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      m_rr = (ch + 1) % 4;
    end
    tick();
    u_if.instr_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    int   ch;
    exp_t e;
    if (!reset && (|u_if.dispatch_valid_o)) begin
      ch = 0;
      for (int i = 0; i < 4; i++) if (u_if.dispatch_valid_o[i]) ch = i;
      check("dispatch_onehot", 64'($countones(u_if.dispatch_valid_o)), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_dispatch", 64'(u_if.dispatch_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("dispatch_chan", 64'(ch), 64'(e.chan));
        check("dispatch_data", 64'(u_if.dispatch_o[ch]), 64'(e.ins));
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset                 = 1'b1;
    u_if.instr_i          = '0;
    u_if.instr_valid_i    = 1'b0;
    u_if.flush_i          = 1'b0;
    u_if.dispatch_ready_i = 4'b1111;
    idle(2);
    reset = 1'b0;

    check("rst_ready", 64'(u_if.instr_ready_o), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(dispatched_count), 64'd0);
    check("rst_valid", 64'(u_if.dispatch_valid_o), 64'd0);
    check("rst_data", 64'(u_if.dispatch_o[0] | u_if.dispatch_o[3]), 64'd0);

`ifdef ICON_SRC_AFFINITY_EN
    push_instr(mk(4'd5, 16'h0501), 0);
    idle(2);
    u_if.dispatch_ready_i = 4'b1110;
    push_instr(mk(4'd5, 16'h0502), -1);
    idle(3);
    check("aff_stall_valid", 64'(u_if.dispatch_valid_o), 64'd0);
    check("aff_stall_busy", 64'(busy), 64'd1);
    u_if.flush_i = 1'b1;
    tick();
    u_if.flush_i = 1'b0;
    idle(1);
    check("aff_flush_empty", 64'(busy), 64'd0);
    push_instr(mk(4'd5, 16'h0502), 1);
    idle(2);
    check("aff_count", 64'(dispatched_count), 64'd2);
`else
    // Sustained round-robin, one-cycle latency.
    push_instr(mk(4'd1, 16'h1001), 0);
    check("latency_ch0", 64'(u_if.dispatch_valid_o), 64'b0001);
    push_instr(mk(4'd2, 16'h1002), 1);
    push_instr(mk(4'd3, 16'h1003), 2);
    push_instr(mk(4'd4, 16'h1004), 3);
    idle(2);
    check("rr_count4", 64'(dispatched_count), 64'd4);

    // Only ch2 ready.
    u_if.dispatch_ready_i = 4'b0100;
    push_instr(mk(4'd6, 16'h2001), 2);
    push_instr(mk(4'd7, 16'h2002), 2);
    push_instr(mk(4'd8, 16'h2003), 2);
    check("ch2_busy_hi", 64'(busy), 64'd1);
    idle(1);
    check("ch2_busy_lo", 64'(busy), 64'd0);
    u_if.dispatch_ready_i = 4'b1111;
    push_instr(mk(4'd9, 16'h2004), 3);
    idle(2);
    check("count8", 64'(dispatched_count), 64'd8);

    // Back-pressure fills the two-entry buffer.
    u_if.dispatch_ready_i = 4'b0000;
    push_instr(mk(4'd1, 16'h3001), 1);
    check("bp_ready_one", 64'(u_if.instr_ready_o), 64'd1);
    push_instr(mk(4'd2, 16'h3002), 1);
    check("bp_ready_full", 64'(u_if.instr_ready_o), 64'd0);
    idle(2);
    check("bp_held", 64'(exp_q.size()), 64'd2);
    u_if.dispatch_ready_i = 4'b0010;
    drain(10);
    idle(1);
    check("bp_ready_back", 64'(u_if.instr_ready_o), 64'd1);
    check("count10", 64'(dispatched_count), 64'd10);

    // Flush on a full buffer with a same-cycle push and every channel ready.
    u_if.dispatch_ready_i = 4'b0000;
    push_instr(mk(4'd3, 16'h4001), -1);
    push_instr(mk(4'd4, 16'h4002), -1);
    check("fl_full", 64'(u_if.instr_ready_o), 64'd0);
    u_if.dispatch_ready_i = 4'b1111;
    u_if.instr_i          = mk(4'd5, 16'h4003);
    u_if.instr_valid_i    = 1'b1;
    u_if.flush_i          = 1'b1;
    tick();
    u_if.instr_valid_i = 1'b0;
    u_if.flush_i       = 1'b0;
    check("fl_state_ready", 64'(u_if.instr_ready_o), 64'd0);
    check("fl_state_busy", 64'(busy), 64'd1);
    check("fl_state_valid", 64'(u_if.dispatch_valid_o), 64'd0);
    tick();
    check("fl_idle_ready", 64'(u_if.instr_ready_o), 64'd1);
    check("fl_idle_busy", 64'(busy), 64'd0);
    check("fl_count_kept", 64'(dispatched_count), 64'd10);
    // rr_ptr preserved: ch1 was last, so ch2 is next.
    push_instr(mk(4'd6, 16'h4004), 2);
    idle(2);
    check("count11", 64'(dispatched_count), 64'd11);

    // Bulk traffic up to 16'hFFFE, then saturation.
    while (exp_cnt != 16'hFFFE) push_instr(mk(exp_cnt[3:0], exp_cnt), m_rr);
    idle(2);
    check("count_fffe", 64'(dispatched_count), 64'hFFFE);
    for (int i = 0; i < 3; i++) push_instr(mk(4'd0, 16'h5000 + 16'(i)), m_rr);
    idle(2);
    check("count_sat", 64'(dispatched_count), 64'hFFFF);

    // Reset mid-operation drops buffered instructions and clears all state.
    u_if.dispatch_ready_i = 4'b0000;
    push_instr(mk(4'd7, 16'h6001), -1);
    push_instr(mk(4'd8, 16'h6002), -1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_ready", 64'(u_if.instr_ready_o), 64'd1);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_count", 64'(dispatched_count), 64'd0);
    u_if.dispatch_ready_i = 4'b1111;
    idle(2);
    push_instr(mk(4'd9, 16'h6003), 0);
    idle(2);
    check("mrst_count1", 64'(dispatched_count), 64'd1);
`endif

    idle(2);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
